jtag_ahb_ap_ctrl: RTL

AHB-Lite access-port controller for the JTAG debug path. It accepts one decoded access-port command per update pulse: the 37-bit ap_shift_t {data, regselect, size, addrinc, r_w}, already synchronized into the system clock domain by the TCK-to-CLK crossing. It then either loads its address register or runs a single AHB-Lite transfer, and holds the read data and status for the next CAPTURE_DR. It sits between the TAP's AHB data register and the SoC AHB-Lite interconnect as a single master.

---
 rtl/jtag_ahb_ap_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/jtag_ahb_ap_ctrl.sv
// JTAG access-port controller: turns one decoded AP command per update pulse into an
// address-register load or a single AHB-Lite transfer, with sticky error/overrun/timeout flags.
module jtag_ahb_ap_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ap_update,
   input  logic [36:0] ap_cmd,
   input  logic        err_clear,
   output logic        busy,
   output logic [31:0] rdata,
   output logic        err,
   output logic        overrun,
   output logic        timeout,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   localparam int               CNT_W       = 16;
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [1:0]       TR_IDLE     = 2'b00;
   localparam logic [1:0]       TR_NONSEQ   = 2'b10;
   localparam logic [1:0]       SZ_BYTE     = 2'b00;
   localparam logic [1:0]       SZ_HALF     = 2'b01;
   localparam logic [1:0]       SZ_WORD     = 2'b10;
   localparam logic             REG_ADDRESS = 1'b0;

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;

   state_e           state_q, state_d;
   logic [31:0]      addr_reg_q, addr_reg_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [31:0]      haddr_q, haddr_d;
   logic [31:0]      hwdata_q, hwdata_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [1:0]       htrans_q, htrans_d;
   logic [2:0]       hsize_q, hsize_d;
   logic             hwrite_q, hwrite_d;
   logic             addrinc_q, addrinc_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             overrun_q, overrun_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic [31:0] cmd_data;
   logic        cmd_regsel;
   logic [1:0]  cmd_size;
   logic        cmd_addrinc;
   logic        cmd_rw;
   logic        cmd_bad;
   logic        set_err, set_ovr, set_to;

   assign cmd_data    = ap_cmd[36:5];
   assign cmd_regsel  = ap_cmd[4];
   assign cmd_size    = ap_cmd[3:2];
   assign cmd_addrinc = ap_cmd[1];
   assign cmd_rw      = ap_cmd[0];

   // Narrow writes drive every byte lane so the slave may pick any of them.
   function automatic logic [31:0] replicate_lanes(input logic [1:0] size, input logic [31:0] data);
      case (size)
         SZ_BYTE: replicate_lanes = {4{data[7:0]}};
         SZ_HALF: replicate_lanes = {2{data[15:0]}};
         default: replicate_lanes = data;
      endcase
   endfunction

   function automatic logic [31:0] extract_lane(input logic [1:0] size, input logic [1:0] offset,
                                                input logic [31:0] bus);
      logic [31:0] shifted;
      shifted = bus >> {offset, 3'b000};
      case (size)
         SZ_BYTE: extract_lane = {24'h0, shifted[7:0]};
         SZ_HALF: extract_lane = {16'h0, shifted[15:0]};
         default: extract_lane = bus;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      addr_reg_d = addr_reg_q;
      rdata_d    = rdata_q;
      haddr_d    = haddr_q;
      hwdata_d   = hwdata_q;
      wdata_d    = wdata_q;
      htrans_d   = htrans_q;
      hsize_d    = hsize_q;
      hwrite_d   = hwrite_q;
      addrinc_d  = addrinc_q;
      busy_d     = busy_q;
      wait_cnt_d = wait_cnt_q;
      set_err    = 1'b0;
      set_ovr    = ap_update && busy_q;
      set_to     = 1'b0;
      cmd_bad    = (cmd_size == 2'b11) ||
                   (cmd_size == SZ_HALF && addr_reg_q[0]) ||
                   (cmd_size == SZ_WORD && addr_reg_q[1:0] != 2'b00);

      case (state_q)
         ST_IDLE: begin
            if (ap_update) begin
               if (cmd_regsel == REG_ADDRESS) begin
                  addr_reg_d = cmd_data;
               end else if (err_q || cmd_bad) begin
                  set_err = 1'b1;
               end else begin
                  state_d   = ST_ADDR;
                  haddr_d   = addr_reg_q;
                  htrans_d  = TR_NONSEQ;
                  hsize_d   = {1'b0, cmd_size};
                  hwrite_d  = cmd_rw;
                  addrinc_d = cmd_addrinc;
                  wdata_d   = replicate_lanes(cmd_size, cmd_data);
                  busy_d    = 1'b1;
               end
            end
         end
         ST_ADDR: begin
            if (HREADY) begin
               state_d  = ST_DATA;
               htrans_d = TR_IDLE;
               hwdata_d = wdata_q;
            end
         end
         ST_DATA: begin
            if (!HREADY) begin
               // The first cycle of an ERROR response is a plain wait; only OKAY waits count.
               if (!HRESP) begin
                  if (wait_cnt_q != '1) begin
                     wait_cnt_d = wait_cnt_q + 1'b1;
                  end
                  if (TIMEOUT != 0 && wait_cnt_d == TIMEOUT_CNT) begin
                     set_to = 1'b1;
                  end
               end
            end else begin
               if (HRESP) begin
                  set_err = 1'b1;
               end else begin
                  if (!hwrite_q) begin
                     rdata_d = extract_lane(hsize_q[1:0], haddr_q[1:0], HRDATA);
                  end
                  if (addrinc_q) begin
                     addr_reg_d = addr_reg_q + (32'd1 << hsize_q[1:0]);
                  end
               end
               state_d    = ST_IDLE;
               busy_d     = 1'b0;
               wait_cnt_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A flag-set event in the same cycle as err_clear takes priority.
      err_d     = (err_q     && !err_clear) || set_err;
      overrun_d = (overrun_q && !err_clear) || set_ovr;
      timeout_d = (timeout_q && !err_clear) || set_to;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         addr_reg_q <= '0;
         rdata_q    <= '0;
         haddr_q    <= '0;
         hwdata_q   <= '0;
         wdata_q    <= '0;
         htrans_q   <= TR_IDLE;
         hsize_q    <= '0;
         hwrite_q   <= 1'b0;
         addrinc_q  <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         overrun_q  <= 1'b0;
         timeout_q  <= 1'b0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_reg_q <= addr_reg_d;
         rdata_q    <= rdata_d;
         haddr_q    <= haddr_d;
         hwdata_q   <= hwdata_d;
         wdata_q    <= wdata_d;
         htrans_q   <= htrans_d;
         hsize_q    <= hsize_d;
         hwrite_q   <= hwrite_d;
         addrinc_q  <= addrinc_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         overrun_q  <= overrun_d;
         timeout_q  <= timeout_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign busy    = busy_q;
   assign rdata   = rdata_q;
   assign err     = err_q;
   assign overrun = overrun_q;
   assign timeout = timeout_q;
   assign HADDR   = haddr_q;
   assign HTRANS  = htrans_q;
   assign HWRITE  = hwrite_q;
   assign HSIZE   = hsize_q;
   assign HWDATA  = hwdata_q;

endmodule
